countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Sequencing controller for the team's down-counter datapath.
- Loads a programmable start value, decrements it on prescaled ticks, and supports pause, abort and a one-cycle completion pulse.
- Sits between software/FSM requesters and the counter register.
- Unlike the free-running down counter, it stops at zero; it never wraps.

Parameters:
- WIDTH, 4: counter and load_val width in bits.
- PRESCALE, 1: clocks per decrement tick; legal range 1..255. The prescaler register is 8 bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- start  input  1  start request; sampled only in IDLE.
- load_val  input  WIDTH  initial count, sampled with start.
- pause  input  1  level; holds the count while high.
- abort  input  1  level; cancels the operation and returns to IDLE.
- count  output  WIDTH  current counter value, registered.
- busy  output  1  high in RUN or PAUSE.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle completion pulse, registered.
- state  output  2  encoded state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, busy=0, ready=1, done=0.
  - Prescaler cleared; reload register cleared.
  - Reset mid-operation abandons the count with no done pulse.
- Outputs are Moore outputs of state:
  - busy=(RUN|PAUSE), ready=IDLE, done=DONE.
  - All outputs are glitch-free and registered.
- Priority in every state: abort > pause > tick/start.
- IDLE:
  - start=1, load_val=N≠0: count<=N, prescaler<=0, next state RUN.
  - start=1, load_val=0: count stays 0, next state DONE.
  - Otherwise hold.
- RUN:
  - Prescaler increments each clock; a tick occurs when prescaler==PRESCALE-1, and the prescaler then wraps to 0.
  - On tick, count<=count-1.
  - On the tick where count==1: count<=0 and next state DONE.
  - pause=1: next state PAUSE. No decrement and no prescaler advance in that cycle, even if a tick was due.
  - abort=1: next state IDLE, count<=0, prescaler<=0.
- PAUSE:
  - count and prescaler frozen.
  - pause=0: back to RUN; the prescaler resumes from its held value.
  - abort=1: IDLE, count<=0.
- DONE:
  - Lasts exactly one cycle (done=1), then IDLE.
  - start during DONE is ignored; it is re-sampled in IDLE on the following cycle.
- start is ignored while busy; no queuing.
- Latency: start sampled at edge E with load_val=N≥1 gives state DONE (done=1) from edge E+N*PRESCALE. count decrements at E+k*PRESCALE for k=1..N.
- Arithmetic: count is unsigned WIDTH bits. A decrement below 0 never occurs: DONE is entered at 0. Maximum load is 2^WIDTH-1.

Optional Feature:
- Macro: COUNTDOWN_CTRL_AUTO_RELOAD_EN.
- Defined:
  - A reload register captures load_val on an accepted start.
  - In DONE, done=1 for one cycle, then count<=reload and next state RUN, with the prescaler cleared. Period = N*PRESCALE+1 clocks.
  - The sequence ends only via abort, which behaves as in RUN and DONE.
  - A load of 0 goes to DONE and then IDLE without reloading.
- Undefined: no reload register; DONE always returns to IDLE.

Test Plan:
- Reset check: rst=0 asynchronously mid-cycle → count=0, state=0, ready=1, busy=0, done=0 before the next clk edge.
- Basic countdown: PRESCALE=1, start with load_val=4 → count 4,3,2,1,0 on successive edges; done=1 exactly at start edge+4 for one cycle; then ready=1.
- Prescaled: PRESCALE=3, load_val=2 → count=2 for 3 clocks, 1 for 3 clocks, then 0; done at start+6.
- Pause/abort: load_val=15, pause held for 5 clocks at count=12 → count stays 12 and state=2, then resumes 11...; separately, abort at count=7 → IDLE, count=0, no done pulse.
- Edge cases: load_val=0 start → done next cycle, count=0; start pulsed during RUN → ignored, count unaffected; abort and pause asserted together → IDLE.
- AUTO_RELOAD_EN defined: load_val=3, PRESCALE=1 → done pulses every 4 clocks with count 3,2,1,0,3,...; abort ends the sequence in IDLE.

Source files
------------

// File: rtl/countdown_ctrl_if.sv
// Request/status bundle between a requester and countdown_ctrl.
// The requester (master) drives start/load_val/pause/abort; the
// controller (slave) returns count and the decoded state flags.
interface countdown_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             ready;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, load_val, pause, abort,
    input  count, busy, ready, done, state
  );

  modport slave (
    input  start, load_val, pause, abort,
    output count, busy, ready, done, state
  );
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: loads a start value, decrements it once every PRESCALE
// clocks and stops at zero with a one-cycle done pulse. Pause freezes the
// count and prescaler; abort returns to IDLE with the count cleared.
// Optional feature macro COUNTDOWN_CTRL_AUTO_RELOAD_EN: after DONE the
// count reloads from the last accepted load_val and runs again, until abort.
module countdown_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic            clk,
  input  logic            rst,
  countdown_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Prescaler value on which a tick fires (prescaler is 8 bits wide).
  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [7:0]       presc_reg, presc_next;
  logic             busy_reg, ready_reg, done_reg;

`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg, reload_next;

  // Reload register: holds load_val of the last accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reload_reg <= '0;
    else      reload_reg <= reload_next;
  end
`endif

  // State, count and prescaler registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      presc_reg <= presc_next;
    end
  end

  // Status flags are registered from the next state so they change
  // together with state and never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg  <= 1'b0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      busy_reg  <= (state_next == RUN) || (state_next == PAUSE);
      ready_reg <= (state_next == IDLE);
      done_reg  <= (state_next == DONE);
    end
  end

  // Next-state logic; priority abort > pause > tick/start in every state.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    presc_next = presc_reg;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
    reload_next = reload_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (!bus.abort && !bus.pause && bus.start) begin
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
          reload_next = bus.load_val;
`endif
          if (bus.load_val != '0) begin
            count_next = bus.load_val;
            presc_next = '0;
            state_next = RUN;
          end else begin
            count_next = '0;
            state_next = DONE;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
          count_next = '0;
          presc_next = '0;
        end else if (bus.pause) begin
          state_next = PAUSE;
        end else if (presc_reg == PRESC_LAST) begin
          presc_next = '0;
          // The last tick lands on zero; a count of 0 here is treated the
          // same way so the counter can never wrap.
          if (count_reg <= WIDTH'(1)) begin
            count_next = '0;
            state_next = DONE;
          end else begin
            count_next = count_reg - WIDTH'(1);
          end
        end else begin
          presc_next = presc_reg + 8'd1;
        end
      end
      PAUSE: begin
        if (bus.abort) begin
          state_next = IDLE;
          count_next = '0;
          presc_next = '0;
        end else if (!bus.pause) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_next = IDLE;
          count_next = '0;
          presc_next = '0;
        end else begin
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
          if (reload_reg != '0) begin
            count_next = reload_reg;
            presc_next = '0;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.count = count_reg;
  assign bus.busy  = busy_reg;
  assign bus.ready = ready_reg;
  assign bus.done  = done_reg;
  assign bus.state = state_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: one instance with PRESCALE=1 and one
// with PRESCALE=3, sharing clock and reset.
module tb_countdown_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  countdown_ctrl_if #(.WIDTH(4)) b1 ();
  countdown_ctrl_if #(.WIDTH(4)) b3 ();

  countdown_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  countdown_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Compare count and state of one instance; busy/ready/done are the
  // expected decodings of the expected state.
  task automatic chk(input string tag, input int which, input int exp_cnt, input int exp_st);
    int c, s, b, r, d;
    if (which == 1) begin
      c = int'(b1.count); s = int'(b1.state); b = int'(b1.busy);
      r = int'(b1.ready); d = int'(b1.done);
    end else begin
      c = int'(b3.count); s = int'(b3.state); b = int'(b3.busy);
      r = int'(b3.ready); d = int'(b3.done);
    end
    check({tag, ".count"}, c, exp_cnt);
    check({tag, ".state"}, s, exp_st);
    check({tag, ".busy"},  b, int'(exp_st == 1 || exp_st == 2));
    check({tag, ".ready"}, r, int'(exp_st == 0));
    check({tag, ".done"},  d, int'(exp_st == 3));
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go1(input int n);
    b1.load_val = 4'(n);
    b1.start    = 1'b1;
    step();
    b1.start    = 1'b0;
  endtask

  initial begin
    b1.start = 0; b1.load_val = 0; b1.pause = 0; b1.abort = 0;
    b3.start = 0; b3.load_val = 0; b3.pause = 0; b3.abort = 0;
    #12;
    chk("reset_hold", 1, 0, 0);
    rst = 1'b1;
    step();

    // Asynchronous reset in the middle of a count.
    go1(5);
    step();
    chk("pre_reset", 1, 4, 1);
    #2 rst = 1'b0;
    #1 chk("async_reset", 1, 0, 0);
    rst = 1'b1;
    step();
    chk("after_reset", 1, 0, 0);

    // Basic countdown, PRESCALE=1.
    go1(4);
    chk("basic_e0", 1, 4, 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("basic_e%0d", k), 1, 4 - k, 1);
    end
    step();
    chk("basic_done", 1, 0, 3);
    step();
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
    chk("basic_reload", 1, 4, 1);
    b1.abort = 1; step(); b1.abort = 0;
    chk("basic_abort", 1, 0, 0);
`else
    chk("basic_idle", 1, 0, 0);
`endif

    // Prescaled countdown, PRESCALE=3.
    b3.load_val = 4'd2; b3.start = 1'b1;
    step();
    b3.start = 1'b0;
    chk("presc_e0", 3, 2, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("presc_e%0d", k), 3, (k < 3) ? 2 : 1, 1);
    end
    step();
    chk("presc_done", 3, 0, 3);
    step();
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
    chk("presc_reload", 3, 2, 1);
    b3.abort = 1; step(); b3.abort = 0;
    chk("presc_abort", 3, 0, 0);
`else
    chk("presc_idle", 3, 0, 0);
`endif

    // Pause at 12 for five clocks, resume, then abort at 7.
    go1(15);
    step(); step(); step();
    chk("pause_at12", 1, 12, 1);
    b1.pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("paused%0d", k), 1, 12, 2);
    end
    b1.pause = 1'b0;
    step();
    chk("resume", 1, 12, 1);
    step();
    chk("resume_dec", 1, 11, 1);
    step(); step(); step(); step();
    chk("abort_at7", 1, 7, 1);
    b1.abort = 1'b1;
    step();
    b1.abort = 1'b0;
    chk("aborted", 1, 0, 0);
    step();
    chk("no_done", 1, 0, 0);

    // Zero load: done on the following cycle, count stays 0.
    go1(0);
    chk("zero_done", 1, 0, 3);
    step();
    chk("zero_idle", 1, 0, 0);

    // start during RUN is ignored; then abort+pause together.
    go1(5);
    step();
    chk("run_e1", 1, 4, 1);
    b1.load_val = 4'd9; b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    chk("start_ignored", 1, 3, 1);
    b1.abort = 1'b1; b1.pause = 1'b1;
    step();
    b1.abort = 1'b0; b1.pause = 1'b0;
    chk("abort_pause", 1, 0, 0);

`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
    // Auto-reload: period of four clocks for load 3, ended by abort.
    go1(3);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("auto_c%0d", k), 1, 3 - (k % 4), ((k % 4) == 3) ? 3 : 1);
      step();
    end
    b1.abort = 1'b1;
    step();
    b1.abort = 1'b0;
    chk("auto_abort", 1, 0, 0);
    go1(0);
    chk("auto_zero_done", 1, 0, 3);
    step();
    chk("auto_zero_idle", 1, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
